// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB-Lite encodings and master FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_LAST = 2'b10
  } mst_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_lite_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_master_if
//  Description : Command, write/read stream and AHB-Lite bus signals of the
//                master; master modport is the DUT view, slave the opposite.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ahb_lite_master_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [3:0]            cmd_len;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  done;

  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  HRDATA, HREADY,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done,
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output HRDATA, HREADY,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done,
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA
  );

endinterface
`default_nettype wire

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_master
//  Description : AHB-Lite master turning single commands into SINGLE/INCR
//                word bursts with streamed write and read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_lite_master_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  mst_state_t            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [3:0]            cnt_q,      cnt_d;
  logic                  write_q,    write_d;
  logic [2:0]            burst_q,    burst_d;
  logic [2:0]            hsize_q,    hsize_d;
  logic                  first_q,    first_d;
  logic                  hold_q,     hold_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic                  dp_last_q,  dp_last_d;
  logic [DATA_WIDTH-1:0] hwdata_q,   hwdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q,  rd_last_d;
  logic                  done_q,     done_d;

  logic    in_addr;
  logic    issue;
  logic    accept;
  htrans_t htrans;

  // A write beat goes out only with data available; once issued and stalled,
  // hold_q keeps it on the bus until the slave takes it.
  always_comb begin
    in_addr = (state_q == ST_ADDR);
    issue   = in_addr && (!write_q || bus.wr_valid || hold_q);
    accept  = issue && bus.HREADY;
    htrans  = HTRANS_IDLE;
    if (issue) begin
      if (first_q) htrans = HTRANS_NONSEQ;
      else         htrans = HTRANS_SEQ;
    end else if (in_addr && !first_q) begin
      htrans = HTRANS_BUSY;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    burst_d    = burst_q;
    hsize_d    = HSIZE_WORD;
    first_d    = first_q;
    hold_d     = hold_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_last_d  = dp_last_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = ST_ADDR;
          addr_d  = bus.cmd_addr & ALIGN_MASK;
          cnt_d   = bus.cmd_len;
          write_d = bus.cmd_write;
          burst_d = (bus.cmd_len == 4'd0) ? HBURST_SINGLE : HBURST_INCR;
          first_d = 1'b1;
          hold_d  = 1'b0;
        end
      end
      ST_ADDR: begin
        hold_d = issue && !bus.HREADY;
        if (accept) begin
          addr_d  = addr_q + ADDR_STEP;
          cnt_d   = cnt_q - 4'd1;
          first_d = 1'b0;
          if (write_q) hwdata_d = bus.wr_data;
          if (cnt_q == 4'd0) state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        if (bus.HREADY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Data-phase pipeline: advances only when the current data phase completes.
    if (bus.HREADY) begin
      dp_valid_d = accept;
      dp_write_d = write_q;
      dp_last_d  = (cnt_q == 4'd0);
      if (dp_valid_q && !dp_write_q) begin
        rd_valid_d = 1'b1;
        rd_data_d  = bus.HRDATA;
        rd_last_d  = dp_last_q;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      burst_q    <= '0;
      hsize_q    <= '0;
      first_q    <= 1'b0;
      hold_q     <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_last_q  <= 1'b0;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      burst_q    <= burst_d;
      hsize_q    <= hsize_d;
      first_q    <= first_d;
      hold_q     <= hold_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_last_q  <= dp_last_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE) && !HRESET;
  assign bus.wr_ready  = accept && write_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.done      = done_q;
  assign bus.HTRANS    = htrans;
  assign bus.HSEL      = (htrans != HTRANS_IDLE);
  assign bus.HADDR     = addr_q;
  assign bus.HWRITE    = write_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.HBURST    = burst_q;
  assign bus.HWDATA    = hwdata_q;

endmodule
`default_nettype wire

// File: doc/ahb_lite_master.md
# ahb_lite_master

AHB-Lite bus master that turns a simple command stream into single or INCR-burst word transfers toward the on-chip RAM slave and other 32-bit AHB-Lite slaves. It accepts one command at a time through a valid/ready port, streams write data in and read data out beat by beat, and drives the pipelined AHB address and data phases. Wait states are honoured through HREADY. The block is the upstream stage of the RAM: its AHB outputs connect directly to the RAM's address-phase inputs.

## Interface
- ADDR_WIDTH, 10, byte-address width; matches the RAM address space.
- DATA_WIDTH, 32, data bus width; transfers are always one full word.
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  word-aligned start byte address; bits [1:0] are ignored and forced to 0.
- cmd_len  in  4  beats minus 1 (0 = SINGLE, 1..15 = INCR of 2..16 beats).
- wr_valid  in  1  write-data beat present.
- wr_ready  out  1  write beat consumed.
- wr_data  in  DATA_WIDTH  write beat.
- rd_valid  out  1  read beat valid, one cycle; no backpressure.
- rd_data  out  DATA_WIDTH  read beat.
- rd_last  out  1  qualifies the final read beat.
- done  out  1  one-cycle pulse when a command completes.
- HSEL  out  1  high whenever HTRANS is not IDLE.
- HADDR  out  ADDR_WIDTH  transfer address.
- HWRITE  out  1  transfer direction.
- HTRANS  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HSIZE  out  3  fixed 010 (word).
- HBURST  out  3  000 SINGLE when cmd_len=0, otherwise 001 INCR.
- HWDATA  out  DATA_WIDTH  write data for the current data phase.
- HRDATA  in  DATA_WIDTH  read data from the slave.
- HREADY  in  1  data-phase completion (slave HREADYOUT).

## Operation
- States:
  - IDLE: cmd_ready = !HRESET; HTRANS = IDLE.
  - ADDR: issues beats.
  - LAST: final data phase only; HTRANS = IDLE.
- IDLE -> ADDR on command acceptance.
  - The command is latched into an address register, a beat counter (cmd_len), the direction and the burst type.
  - The first address phase appears the next cycle.
- ADDR, beat type:
  - First beat is NONSEQ; later beats are SEQ.
  - A read beat is always issued.
  - A write beat is issued only if wr_valid=1. Otherwise the first beat is held as IDLE with HSEL=0, and a later beat is driven as BUSY, with HADDR already at the next address.
- Beat accepted (HTRANS NONSEQ/SEQ with HREADY=1):
  - Address increments by 4 modulo 2^ADDR_WIDTH; the top of the space wraps to 0.
  - Counter decrements.
  - For writes, wr_ready pulses in the same cycle and wr_data is registered into HWDATA for the following data phase.
  - If the counter was 0, next state is LAST.
- LAST -> IDLE when HREADY=1.
- Read data: each read data phase that completes with HREADY=1 produces rd_valid=1 and rd_data=HRDATA in the next cycle. rd_last is set with the final beat.
- done pulses in the cycle after the final data phase completes; cmd_ready is also high in that cycle.
- HRESP is not supported; slaves are OKAY-only.

## Timing
- Reset (HRESET=1 at an edge): every output is 0, so HTRANS=00 and HSEL=0. State returns to IDLE. This holds mid-burst too: the burst is abandoned with no done and no further wr_ready or rd_valid.
- HREADY=0 stalls the bus. HADDR, HTRANS, HWRITE and HWDATA hold stable, and the counter and address do not advance.
- Single transfer with no wait states:
  - Accept at cycle N.
  - NONSEQ at N+1.
  - Data phase at N+2.
  - done at N+3; rd_valid also at N+3 for a read.
- An n-beat burst with no stalls occupies n+1 bus cycles. Address and data phases overlap.
- HWDATA changes only when a write address phase is accepted, and holds otherwise.
- A cmd_valid that arrives while busy is not accepted; it waits for IDLE.

## Structure
- Shared package ahb_pkg:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE_WORD, HBURST_SINGLE and HBURST_INCR constants.
  - Master state enum.
- Single module; no sub-module. The address and beat counter are inline.

## Test plan
- Single write, cmd_addr=0x010, cmd_len=0, wr_data=0xDEADBEEF:
  - N+1: HTRANS=10, HADDR=0x010, HWRITE=1, HBURST=000, wr_ready=1.
  - N+2: HWDATA=0xDEADBEEF, HTRANS=00.
  - N+3: done=1.
- 4-beat read from 0x020 against the RAM preloaded with 0x11111111..0x44444444:
  - HADDR 0x020/0x024/0x028/0x02C with HTRANS 10/11/11/11, HBURST=001.
  - Four rd_valid pulses in order; rd_last on the 4th.
- Wait states: HREADY=0 for 2 cycles during the beat-2 data phase of a 3-beat write.
  - All AHB outputs hold stable; no wr_ready.
  - Resumes with correct addresses; done is 2 cycles later than without the stall.
- Write burst, cmd_len=2, wr_valid low for one cycle before beat 2:
  - HTRANS sequence 10, 01, 11, 11 (the first 11 re-issues beat 2 once wr_valid rises), with HADDR=0x004 during BUSY.
  - Exactly 3 wr_ready pulses.
- Wrap: cmd_addr=0x3F8, cmd_len=3 -> HADDR 0x3F8, 0x3FC, 0x000, 0x004.
- Reset at beat 2 of a 4-beat read:
  - Next cycle HTRANS=00, HSEL=0, and no done.
  - First cycle after release: cmd_ready=1.
